// File: rtl/array_word_streamer.sv
// Snapshots an N-word array on start and serialises a wrapping window of it
// onto a single-word valid/ready stream.
module array_word_streamer #(
    parameter  int N  = 8,
    parameter  int DW = 32,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int LW = $clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] arr_i [N],
    input  logic          start_i,
    input  logic [IW-1:0] base_i,
    input  logic [LW-1:0] len_i,
    output logic          busy_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] data_o,
    output logic [IW-1:0] idx_o,
    output logic          last_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q;
    logic [DW-1:0] buf_q [N];
    logic [DW-1:0] data_q;
    logic [IW-1:0] idx_q;
    logic [LW-1:0] rem_q;
    logic          valid_q, last_q, busy_q, done_q, err_q;

    logic          len_ok_d;
    logic          capture_d;
    logic [IW-1:0] nidx_d;

    always_comb begin
        len_ok_d  = (len_i != '0) && (len_i <= LW'(N));
        capture_d = (state_q == IDLE) && start_i && len_ok_d;
        // explicit compare keeps the wrap correct for non-power-of-2 N
        nidx_d    = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    end

    // Snapshot buffer carries no reset; its contents only matter after a capture.
    always_ff @(posedge clk_i) begin
        if (capture_d) begin
            buf_q <= arr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (len_ok_d) begin
                            idx_q   <= base_i;
                            rem_q   <= len_i;
                            data_q  <= arr_i[base_i];
                            last_q  <= (len_i == LW'(1));
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= STREAM;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (valid_q && ready_i) begin
                        if (rem_q == LW'(1)) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            idx_q  <= nidx_d;
                            rem_q  <= rem_q - 1'b1;
                            data_q <= buf_q[nidx_d];
                            last_q <= (rem_q == LW'(2));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;
    assign last_o  = last_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_array_word_streamer.sv
// Directed bench for array_word_streamer: windows, wrap, backpressure,
// snapshot isolation, illegal/ignored starts, back-to-back and reset.
module tb_array_word_streamer;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int IW = 3;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] arr [N];
    logic          start;
    logic [IW-1:0] base;
    logic [LW-1:0] len;
    logic          busy, valid, ready, last, done, err;
    logic [DW-1:0] data;
    logic [IW-1:0] idx;

    int errors = 0;
    int checks = 0;

    array_word_streamer #(.N(N), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst), .arr_i(arr), .start_i(start),
        .base_i(base), .len_i(len), .busy_o(busy), .valid_o(valid),
        .ready_i(ready), .data_o(data), .idx_o(idx), .last_o(last),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [IW-1:0] eidx,
                            input logic [DW-1:0] edata, input logic elast);
        chk({tag, ".valid"}, valid, 1);
        chk({tag, ".busy"},  busy,  1);
        chk({tag, ".idx"},   idx,   eidx);
        chk({tag, ".data"},  data,  edata);
        chk({tag, ".last"},  last,  elast);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"},  done,  1);
        chk({tag, ".valid"}, valid, 0);
        chk({tag, ".busy"},  busy,  0);
        chk({tag, ".last"},  last,  0);
    endtask

    initial begin
        logic [IW-1:0] exp_idx [8];
        logic          rpat [6];
        int            xfers;

        for (int k = 0; k < N; k++) arr[k] = 32'h1000_0000 + k;
        rst = 1'b1; start = 1'b0; base = '0; len = '0; ready = 1'b0;
        tick();
        chk("rst.valid", valid, 0);
        chk("rst.busy",  busy,  0);
        chk("rst.done",  done,  0);
        chk("rst.err",   err,   0);
        chk("rst.last",  last,  0);
        chk("rst.data",  data,  0);
        chk("rst.idx",   idx,   0);
        rst = 1'b0;
        tick();

        // basic window with wrap: base 6, len 4
        exp_idx[0] = 6; exp_idx[1] = 7; exp_idx[2] = 0; exp_idx[3] = 1;
        start = 1'b1; base = 6; len = 4; ready = 1'b1;
        chk("basic.pre_valid", valid, 0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_word("basic", exp_idx[i], 32'h1000_0000 + 32'(exp_idx[i]), i == 3);
            tick();
        end
        chk_done("basic");
        tick();
        chk("basic.done_clear", done, 0);

        // backpressure: base 0, len 3, ready 0,0,1,0,1,1
        rpat[0] = 0; rpat[1] = 0; rpat[2] = 1; rpat[3] = 0; rpat[4] = 1; rpat[5] = 1;
        ready = 1'b0; start = 1'b1; base = 0; len = 3;
        tick();
        start = 1'b0;
        xfers = 0;
        for (int c = 0; c < 6; c++) begin
            ready = rpat[c];
            chk_word("bp", IW'(xfers), 32'h1000_0000 + 32'(xfers), xfers == 2);
            chk("bp.no_done", done, 0);
            tick();
            if (rpat[c]) xfers++;
        end
        chk_done("bp");
        tick();

        // snapshot isolation: single word
        arr[2] = 32'hAAAA_AAAA;
        ready = 1'b0; start = 1'b1; base = 2; len = 1;
        tick();
        start = 1'b0;
        arr[2] = 32'h5555_5555;
        chk_word("snap1", 2, 32'hAAAA_AAAA, 1);
        tick();
        chk_word("snap1.hold", 2, 32'hAAAA_AAAA, 1);
        ready = 1'b1;
        tick();
        chk_done("snap1");
        tick();

        // snapshot isolation: second word comes from the buffer
        arr[3] = 32'h3333_3333;
        start = 1'b1; base = 2; len = 2;
        tick();
        start = 1'b0;
        arr[3] = 32'hDEAD_BEEF;
        chk_word("snap2.w0", 2, 32'h5555_5555, 0);
        tick();
        chk_word("snap2.w1", 3, 32'h3333_3333, 1);
        tick();
        chk_done("snap2");
        arr[2] = 32'h1000_0002; arr[3] = 32'h1000_0003;
        tick();

        // illegal starts in IDLE
        start = 1'b1; base = 0; len = 0;
        tick();
        start = 1'b0;
        chk("err0.err", err, 1);
        chk("err0.valid", valid, 0);
        chk("err0.busy", busy, 0);
        tick();
        chk("err0.clear", err, 0);
        chk("err0.valid2", valid, 0);
        start = 1'b1; len = 9;
        tick();
        start = 1'b0;
        chk("err9.err", err, 1);
        chk("err9.valid", valid, 0);
        tick();

        // start with len 9 mid-stream is ignored
        start = 1'b1; base = 4; len = 3;
        tick();
        base = 0; len = 9;
        chk_word("ign.w0", 4, 32'h1000_0004, 0);
        tick();
        chk_word("ign.w1", 5, 32'h1000_0005, 0);
        chk("ign.err1", err, 0);
        tick();
        chk_word("ign.w2", 6, 32'h1000_0006, 1);
        chk("ign.err2", err, 0);
        start = 1'b0;
        tick();
        chk_done("ign");
        chk("ign.err3", err, 0);
        tick();

        // full window base 5 then back-to-back restart in the done cycle
        exp_idx[0] = 5; exp_idx[1] = 6; exp_idx[2] = 7; exp_idx[3] = 0;
        exp_idx[4] = 1; exp_idx[5] = 2; exp_idx[6] = 3; exp_idx[7] = 4;
        start = 1'b1; base = 5; len = 8;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_word("full", exp_idx[i], 32'h1000_0000 + 32'(exp_idx[i]), i == 7);
            tick();
        end
        chk_done("full");
        start = 1'b1; base = 0; len = 2;
        tick();
        start = 1'b0;
        chk_word("b2b.w0", 0, 32'h1000_0000, 0);
        chk("b2b.done_clear", done, 0);
        tick();
        chk_word("b2b.w1", 1, 32'h1000_0001, 1);
        tick();
        chk_done("b2b");
        tick();

        // reset after the 2nd transfer of a len 6 window
        start = 1'b1; base = 0; len = 6;
        tick();
        start = 1'b0;
        chk_word("rstm.w0", 0, 32'h1000_0000, 0);
        tick();
        chk_word("rstm.w1", 1, 32'h1000_0001, 0);
        tick();
        chk_word("rstm.w2", 2, 32'h1000_0002, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm.valid", valid, 0);
        chk("rstm.busy",  busy,  0);
        chk("rstm.done",  done,  0);
        chk("rstm.data",  data,  0);
        chk("rstm.idx",   idx,   0);
        chk("rstm.last",  last,  0);
        tick();
        chk("rstm.done2",  done,  0);
        chk("rstm.valid2", valid, 0);
        start = 1'b1; base = 3; len = 1;
        tick();
        start = 1'b0;
        chk_word("rstm.fresh", 3, 32'h1000_0003, 1);
        tick();
        chk_done("rstm.fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
